// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and widths for the instruction-memory loader
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    FINISH,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - little-endian byte-to-word packer with a held output word
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_lane_last,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [1:0]        r_idx;
  logic [23:0]       r_lanes;
  logic              r_word_valid;
  logic [WORD_W-1:0] r_word;

  // Lanes 0-2 collect the next word while r_word still presents the previous one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx        <= 2'd0;
      r_lanes      <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_lanes[7:0]   <= i_byte;
          2'd1:    r_lanes[15:8]  <= i_byte;
          2'd2:    r_lanes[23:16] <= i_byte;
          default: begin
            r_word       <= {i_byte, r_lanes};
            r_word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_lane_last  = (r_idx == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed program into instruction memory, holding the CPU in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int          TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_n;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TO_W-1:0]       r_idle;

  logic        w_accept;
  logic        w_loading;
  logic        w_lane_last;
  logic        w_word_done;
  logic        w_last_word;
  logic        w_timeout;
  logic [15:0] w_n_full;

  assign rx_ready    = (r_state == HDR_LO) || (r_state == HDR_HI) || (r_state == DATA);
  assign w_accept    = rx_valid && rx_ready;
  assign w_loading   = (r_state == HDR_HI) || (r_state == DATA);
  assign w_word_done = w_accept && (r_state == DATA) && w_lane_last;
  assign w_last_word = (17'(r_words) + 17'd1) == 17'(r_n);
  assign w_n_full    = {rx_data, r_n[7:0]};
  // Acceptance always beats the idle limit.
  assign w_timeout   = w_loading && !w_accept && (r_idle == TO_W'(TIMEOUT_CYCLES - 1));

  imem_loader_word_assembler u_asm (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_valid      (w_accept && (r_state == DATA)),
    .i_byte       (rx_data),
    .o_lane_last  (w_lane_last),
    .o_word_valid (imem_we),
    .o_word       (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HDR_LO;
      r_n     <= 16'd0;
      r_words <= '0;
      r_addr  <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && (r_state == HDR_LO)) r_n[7:0]  <= rx_data;
      if (w_accept && (r_state == HDR_HI)) r_n[15:8] <= rx_data;
      // Address is latched with the pre-increment count so it lines up with the write pulse.
      if (w_word_done) begin
        r_addr  <= r_words[ADDR_WIDTH-1:0];
        r_words <= r_words + 1'b1;
      end
      if (w_accept || !w_loading) r_idle <= '0;
      else                        r_idle <= r_idle + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR_LO: if (w_accept) w_next = HDR_HI;
      HDR_HI: begin
        if (w_accept) begin
          if (w_n_full == 16'd0)              w_next = DONE;
          else if (17'(w_n_full) > CAPACITY)  w_next = ERROR;
          else                                w_next = DATA;
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      DATA: begin
        if (w_word_done && w_last_word) w_next = FINISH;
        else if (w_timeout)             w_next = ERROR;
      end
      FINISH:  w_next = DONE;
      default: w_next = r_state;
    endcase
  end

  assign imem_addr    = r_addr;
  assign words_loaded = r_words;
  assign cpu_reset    = (r_state != DONE);
  assign load_done    = (r_state == DONE);
  assign load_error   = (r_state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized bench for imem_loader against a byte-count reference model
module tb_imem_loader;

  localparam int AW = 5;
  localparam int T  = 20;
  localparam int CAP = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: counts accepted bytes, derives the expected outputs from the stream rules.
  int          m_bytes, m_n, m_words, m_idle;
  bit          m_done, m_err, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  m_buf [4];
  bit          started = 1'b0;

  logic [31:0] tb_mem  [CAP];
  logic [31:0] exp_mem [CAP];
  int          n_writes = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;

  function automatic void m_reset();
    m_bytes = 0; m_n = 0; m_words = 0; m_idle = 0;
    m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = 32'd0;
  endfunction

  always @(negedge clk) begin
    bit fin, acc;
    int k;
    fin = (m_n > 0) && (m_bytes == 2 + 4 * m_n) && !m_done && !m_err;
    if (started) begin
      chk("rx_ready", 32'(rx_ready), 32'(!(m_done || m_err || fin)));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("cpu_reset", 32'(cpu_reset), 32'(!m_done));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_error", 32'(load_error), 32'(m_err));
      chk("words_loaded", 32'(words_loaded), 32'(m_words));
      if (imem_we === 1'b1) begin
        tb_mem[imem_addr] = imem_wdata;
        n_writes++;
        last_we_cyc = cyc;
      end
      if (load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end
    acc = rx_valid && !(m_done || m_err || fin);
    if (reset) begin
      m_reset();
      started = 1'b1;
    end else if (started) begin
      m_we = 1'b0;
      if (acc) begin
        m_idle = 0;
        if (m_bytes == 0) begin
          m_n = int'(rx_data);
        end else if (m_bytes == 1) begin
          m_n = m_n + int'(rx_data) * 256;
          if (m_n == 0) m_done = 1'b1;
          else if (m_n > CAP) m_err = 1'b1;
        end else begin
          k = m_bytes - 2;
          m_buf[k % 4] = rx_data;
          if (k % 4 == 3) begin
            m_we = 1'b1;
            m_addr = AW'(k / 4);
            m_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            m_words++;
          end
        end
        m_bytes++;
      end else if (m_bytes >= 1 && !fin && !m_done && !m_err) begin
        m_idle++;
        if (m_idle == T) m_err = 1'b1;
      end
      if (fin) m_done = 1'b1;
    end
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = (rx_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_accept: byte 0x%0h never accepted, rx_ready=%b", b, rx_ready);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_writes = 0;
    last_we_cyc = -1;
    done_cyc = -1;
  endtask

  // Header then, for a legal length, 4*n random data bytes; gaps up to maxgap idle cycles.
  task automatic send_stream(input int n, input int maxgap);
    logic [7:0] b;
    idle($urandom_range(0, maxgap));
    send(8'(n));
    idle($urandom_range(0, maxgap));
    send(8'(n >> 8));
    if (n == 0 || n > CAP) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      exp_mem[i / 4][8 * (i % 4) +: 8] = b;
      idle($urandom_range(0, maxgap));
      send(b);
    end
  endtask

  task automatic send_nominal(input int gap);
    logic [7:0] s [10];
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    for (int i = 0; i < 10; i++) begin
      idle(gap);
      send(s[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    send_nominal(0);
    idle(3);
    chk("nom_word0", tb_mem[0], 32'h00A00513);
    chk("nom_word1", tb_mem[1], 32'h00B00593);
    chk("nom_writes", 32'(n_writes), 32'd2);
    chk("nom_done_lag", 32'(done_cyc - last_we_cyc), 32'd1);
    chk("nom_words", 32'(words_loaded), 32'd2);

    do_reset();
    tb_mem[0] = 32'd0;
    tb_mem[1] = 32'd0;
    send_nominal(3);
    chk("gap_ready_after_last", 32'(rx_ready), 32'd0);
    idle(3);
    chk("gap_word0", tb_mem[0], 32'h00A00513);
    chk("gap_word1", tb_mem[1], 32'h00B00593);
    chk("gap_done", 32'(load_done), 32'd1);

    do_reset();
    send(8'h00);
    send(8'h00);
    chk("empty_done", 32'(load_done), 32'd1);
    chk("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    idle(3);
    chk("empty_writes", 32'(n_writes), 32'd0);

    do_reset();
    send_stream(33, 0);
    idle(3);
    chk("ovf_error", 32'(load_error), 32'd1);
    chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("ovf_writes", 32'(n_writes), 32'd0);

    do_reset();
    send_stream(32, 0);
    idle(3);
    chk("full_words", 32'(words_loaded), 32'd32);
    chk("full_last_addr", 32'(imem_addr), 32'd31);
    chk("full_last_word", tb_mem[31], exp_mem[31]);
    chk("full_writes", 32'(n_writes), 32'd32);

    do_reset();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(T);
    chk("to_error", 32'(load_error), 32'd1);
    idle(2);
    chk("to_writes", 32'(n_writes), 32'd0);

    do_reset();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(T - 1);
    chk("to_edge_no_error", 32'(load_error), 32'd0);
    send(8'h33); send(8'h44);
    idle(3);
    chk("to_edge_done", 32'(load_done), 32'd1);
    chk("to_edge_word", tb_mem[0], 32'h44332211);

    do_reset();
    send(8'h03); send(8'h00);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    do_reset();
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_ready", 32'(rx_ready), 32'd1);
    send_stream(2, 1);
    idle(3);
    chk("midrst_word0", tb_mem[0], exp_mem[0]);
    chk("midrst_word1", tb_mem[1], exp_mem[1]);

    for (int it = 0; it < 24; it++) begin
      do_reset();
      case ($urandom_range(0, 7))
        0:       n = 0;
        1:       n = $urandom_range(CAP + 1, 600);
        default: n = $urandom_range(1, 8);
      endcase
      send_stream(n, $urandom_range(0, 3));
      idle(4);
      if (n >= 1 && n <= CAP) begin
        chk("rnd_done", 32'(load_done), 32'd1);
        for (int w = 0; w < n; w++) chk("rnd_word", tb_mem[w], exp_mem[w]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
